// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump/call/return sequencing and a circular return-address stack.
module pc_sequencer #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] INC      = WIDTH'(1),
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] rs1_reg,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] op_a,
  output logic             redirect,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ret_err
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_redirect;
  logic             r_ret_err;
  logic             r_ovf;

  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_next_pc;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_ptr_dec;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_rerr;
  logic             w_push;
  logic             w_repl;
  logic             w_redir;

  // r_ptr is the next write slot; the top lives one slot below it
  always_comb begin
    w_seq     = r_pc + INC;
    w_ptr_inc = (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
    w_ptr_dec = (r_ptr == '0) ? LAST : r_ptr - PW'(1);
    w_top     = r_ras[w_ptr_dec];
    w_empty   = (r_cnt == '0);
    w_full    = (r_cnt == FULL);
    w_pop     = !stall && ret && !w_empty;
    w_rerr    = !stall && ret && w_empty;
    w_push    = !stall && jump && call && !ret;
    w_repl    = w_pop && jump && call;
    w_redir   = w_pop || (!stall && !ret && (jump || branch));
    w_next_pc = stall  ? r_pc :
                w_pop  ? w_top :
                w_rerr ? w_seq :
                jump   ? rs1_reg + imm :
                branch ? r_pc + imm : w_seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_redirect <= 1'b0;
      r_ret_err  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_redirect <= w_redir;
      r_ret_err  <= w_rerr;
      if (w_push) begin
        r_ptr <= w_ptr_inc;
        r_cnt <= w_full ? r_cnt : r_cnt + CW'(1);
        if (w_full) r_ovf <= 1'b1;
      end else if (w_pop && !w_repl) begin
        r_ptr <= w_ptr_dec;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // entries need no reset: occupancy alone decides what is readable
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_ptr] <= w_seq;
    else if (w_repl) r_ras[w_ptr_dec] <= w_seq;
  end

  assign pc        = r_pc;
  assign op_a      = (branch || jump) ? rs1_reg : r_pc;
  assign redirect  = r_redirect;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ret_err   = r_ret_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] rs1_reg = '0, imm = '0;
  logic [15:0] pc, op_a;
  logic        redirect, ras_empty, ras_full, ras_ovf, ret_err;
  int          errors = 0, checks = 0;
  logic [15:0] exp_pc;
  logic [15:0] pushed [5];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jump(jump),
    .call(call), .ret(ret), .rs1_reg(rs1_reg), .imm(imm), .pc(pc), .op_a(op_a),
    .redirect(redirect), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic jp, input logic ca,
                       input logic rt, input logic [15:0] rs, input logic [15:0] im);
    stall = st; branch = br; jump = jp; call = ca; ret = rt; rs1_reg = rs; imm = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_empty", ras_empty, 1);
    check("rst_redirect", redirect, 0);
    check("rst_ovf", ras_ovf, 0);
    check("rst_ret_err", ret_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("idle_pc%0d", i), pc, 32'(i));
      check("idle_redirect", redirect, 0);
    end
    check("idle_empty", ras_empty, 1);

    drive(0, 0, 1, 0, 0, 16'h0010, 16'h0000);
    #1 check("op_a_jump", op_a, 16'h0010);
    tick();
    check("jump_pc", pc, 16'h0010);
    drive(0, 0, 1, 1, 0, 16'h0100, 16'h0004);
    tick();
    check("call_pc", pc, 16'h0104);
    check("call_redirect", redirect, 1);
    check("call_not_empty", ras_empty, 0);
    drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    tick();
    check("ret_pc", pc, 16'h0011);
    check("ret_redirect", redirect, 1);
    check("ret_empty", ras_empty, 1);
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    check("seq_pc", pc, 16'h0012);
    check("seq_redirect", redirect, 0);

    exp_pc = 16'h0012;
    for (int k = 0; k < 5; k++) begin
      pushed[k] = exp_pc + 16'h0001;
      exp_pc = 16'(16'h0200 * (k + 1));
      drive(0, 0, 1, 1, 0, exp_pc, 16'h0000);
      tick();
      check($sformatf("push%0d_pc", k), pc, exp_pc);
      if (k == 3) begin
        check("full_at4", ras_full, 1);
        check("no_ovf_at4", ras_ovf, 0);
      end
    end
    check("full_at5", ras_full, 1);
    check("ovf_at5", ras_ovf, 1);
    drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    for (int k = 4; k >= 1; k--) begin
      tick();
      check($sformatf("pop%0d_pc", k), pc, pushed[k]);
      check("pop_ret_err", ret_err, 0);
    end
    check("pop_empty", ras_empty, 1);
    tick();
    check("uflow_pc", pc, pushed[1] + 16'h0001);
    check("uflow_ret_err", ret_err, 1);
    check("uflow_redirect", redirect, 0);
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    check("uflow_ret_err_clear", ret_err, 0);
    check("ovf_sticky", ras_ovf, 1);

    #2 rst_n = 1'b0;
    #1 check("rst2_ovf", ras_ovf, 0);
    @(negedge clk) rst_n = 1'b1;

    drive(0, 0, 1, 0, 0, 16'hFFFF, 16'h0000);
    tick();
    check("pc_ffff", pc, 16'hFFFF);
    drive(0, 1, 0, 0, 0, 16'h1234, 16'h0002);
    #1 check("op_a_branch", op_a, 16'h1234);
    tick();
    check("wrap_pc", pc, 16'h0001);
    check("wrap_redirect", redirect, 1);
    drive(0, 0, 0, 0, 0, 16'h1234, 16'h0000);
    #1 check("op_a_idle", op_a, 16'h0001);
    drive(0, 0, 1, 0, 0, 16'hFFF0, 16'h0020);
    tick();
    check("jump_wrap_pc", pc, 16'h0010);
    drive(0, 1, 0, 0, 0, 16'h0000, 16'hFFFE);
    tick();
    check("branch_neg_pc", pc, 16'h000E);
    drive(0, 1, 1, 0, 0, 16'h0040, 16'h0001);
    tick();
    check("jump_over_branch", pc, 16'h0041);
    drive(0, 0, 0, 1, 0, 16'h0900, 16'h0000);
    tick();
    check("call_only_pc", pc, 16'h0042);
    check("call_only_empty", ras_empty, 1);
    check("call_only_redirect", redirect, 0);

    drive(0, 0, 1, 1, 0, 16'h0300, 16'h0000);
    tick();
    check("swap_push_pc", pc, 16'h0300);
    drive(0, 0, 1, 1, 1, 16'h0500, 16'h0000);
    tick();
    check("swap_pc", pc, 16'h0043);
    check("swap_not_empty", ras_empty, 0);
    check("swap_redirect", redirect, 1);
    drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    tick();
    check("swap_pop_pc", pc, 16'h0301);
    check("swap_pop_empty", ras_empty, 1);

    drive(0, 0, 1, 1, 0, 16'h0700, 16'h0000);
    tick();
    drive(1, 1, 1, 0, 1, 16'h0800, 16'h0004);
    tick();
    check("stall_pc", pc, 16'h0700);
    check("stall_redirect", redirect, 0);
    check("stall_not_empty", ras_empty, 0);
    check("stall_ret_err", ret_err, 0);
    drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    tick();
    check("post_stall_pop", pc, 16'h0302);

    drive(0, 0, 1, 1, 0, 16'h0A00, 16'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 16'h0000);
    check("async_rst_empty", ras_empty, 1);
    check("async_rst_redirect", redirect, 0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_pc", pc, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
